// File: rtl/pkt_wrr_arb_avlstrm_if.sv
// rtl/pkt_wrr_arb_avlstrm_if.sv - ingress/egress packet stream and config bundle for pkt_wrr_arb_avlstrm
interface pkt_wrr_arb_avlstrm_if #(
    parameter int N  = 5,
    parameter int DW = 512,
    parameter int WW = 4
);
    localparam int EW = $clog2(DW / 8);

    logic [N*WW-1:0] cfg_weight;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_sop;
    logic [N-1:0]    in_eop;
    logic [N*EW-1:0] in_empty;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_sop;
    logic            out_eop;
    logic [EW-1:0]   out_empty;
    logic            out_almostfull;
    logic [N-1:0]    grant_vec;
    logic [N*32-1:0] stat_pkt_cnt;

    modport master (
        output cfg_weight, in_valid, in_data, in_sop, in_eop, in_empty,
        output out_ready, out_almostfull,
        input  in_ready, out_valid, out_data, out_sop, out_eop, out_empty,
        input  grant_vec, stat_pkt_cnt
    );

    modport slave (
        input  cfg_weight, in_valid, in_data, in_sop, in_eop, in_empty,
        input  out_ready, out_almostfull,
        output in_ready, out_valid, out_data, out_sop, out_eop, out_empty,
        output grant_vec, stat_pkt_cnt
    );
endinterface

// File: rtl/pkt_wrr_arb_avlstrm.sv
// rtl/pkt_wrr_arb_avlstrm.sv - packet-atomic WRR N:1 Avalon-ST arbiter; PKT_ARB_STATS_EN adds per-port packet counters
module pkt_wrr_arb_avlstrm #(
    parameter int N  = 5,
    parameter int DW = 512,
    parameter int WW = 4
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    pkt_wrr_arb_avlstrm_if.slave   bus
);
    localparam int EW = $clog2(DW / 8);
    localparam int GW = $clog2(N);

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   g_q, g_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WW-1:0]   credit_q, credit_d;
    logic            in_pkt_q, in_pkt_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_sop_q, out_sop_d;
    logic            out_eop_q, out_eop_d;
    logic [EW-1:0]   out_empty_q, out_empty_d;
    logic [N-1:0]    grant_vec_q, grant_vec_d;

    logic            take;
    logic            xfer_open;
    logic            accept;
    logic [N-1:0]    in_ready;
    logic [DW-1:0]   sel_data;
    logic            sel_sop;
    logic            sel_eop;
    logic [EW-1:0]   sel_empty;
    logic [GW-1:0]   next_g;
    logic            scan_found;
    logic [GW-1:0]   scan_idx;
    logic [GW:0]     scan_cand;
    logic [WW-1:0]   scan_weight;

    assign sel_data  = bus.in_data[int'(g_q)*DW +: DW];
    assign sel_sop   = bus.in_sop[g_q];
    assign sel_eop   = bus.in_eop[g_q];
    assign sel_empty = bus.in_empty[int'(g_q)*EW +: EW];
    assign next_g    = (g_q == GW'(N - 1)) ? '0 : g_q + GW'(1);

    // Beat handshake: the output register can take a beat when empty or draining this cycle.
    always_comb begin
        take      = !out_valid_q || bus.out_ready;
        xfer_open = (state_q == XFER) && take && !bus.out_almostfull;
        accept    = xfer_open && bus.in_valid[g_q];
        in_ready  = '0;
        for (int i = 0; i < N; i++) begin
            if (xfer_open && (g_q == GW'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // Round-robin scan: first valid port at or after rr_ptr, wrapping modulo N.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        scan_cand  = '0;
        for (int k = 0; k < N; k++) begin
            scan_cand = {1'b0, rr_ptr_q} + (GW+1)'(k);
            if (scan_cand >= (GW+1)'(N)) begin
                scan_cand = scan_cand - (GW+1)'(N);
            end
            if (!scan_found && bus.in_valid[scan_cand[GW-1:0]]) begin
                scan_found = 1'b1;
                scan_idx   = scan_cand[GW-1:0];
            end
        end
        scan_weight = bus.cfg_weight[int'(scan_idx)*WW +: WW];
    end

    // Next-state: grant selection, packet-atomic credit accounting and egress register load.
    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        rr_ptr_d    = rr_ptr_q;
        credit_d    = credit_q;
        in_pkt_d    = in_pkt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_empty_d = out_empty_q;
        grant_vec_d = '0;

        case (state_q)
            IDLE: begin
                if (scan_found) begin
                    state_d  = XFER;
                    g_d      = scan_idx;
                    credit_d = (scan_weight == '0) ? WW'(1) : scan_weight;
                    in_pkt_d = 1'b0;
                end
            end
            XFER: begin
                if (accept) begin
                    if (sel_eop) begin
                        in_pkt_d = 1'b0;
                        credit_d = credit_q - WW'(1);
                        if (credit_q <= WW'(1)) begin
                            state_d  = IDLE;
                            rr_ptr_d = next_g;
                        end
                    end else begin
                        in_pkt_d = 1'b1;
                    end
                end else if (!in_pkt_q && !bus.in_valid[g_q]) begin
                    // Granted port has nothing at a packet boundary: give up the rest of the turn.
                    state_d  = IDLE;
                    rr_ptr_d = next_g;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == XFER) begin
            grant_vec_d[g_d] = 1'b1;
        end

        if (take) begin
            out_valid_d = accept;
            if (accept) begin
                out_data_d  = sel_data;
                out_sop_d   = sel_sop;
                out_eop_d   = sel_eop;
                out_empty_d = sel_empty;
            end
        end
    end

    // State and egress registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            g_q         <= '0;
            rr_ptr_q    <= '0;
            credit_q    <= '0;
            in_pkt_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_empty_q <= '0;
            grant_vec_q <= '0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            rr_ptr_q    <= rr_ptr_d;
            credit_q    <= credit_d;
            in_pkt_q    <= in_pkt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_empty_q <= out_empty_d;
            grant_vec_q <= grant_vec_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_eop   = out_eop_q;
    assign bus.out_empty = out_empty_q;
    assign bus.grant_vec = grant_vec_q;

`ifdef PKT_ARB_STATS_EN
    logic [31:0] stat_q [N];
    logic [31:0] stat_d [N];

    // Count each accepted end-of-packet against the granted port; 32-bit wrap is intended.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            stat_d[i] = stat_q[i];
        end
        if (accept && sel_eop) begin
            stat_d[g_q] = stat_q[g_q] + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < N; i++) begin
            if (!Rst_n) begin
                stat_q[i] <= '0;
            end else begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_stat
        assign bus.stat_pkt_cnt[gi*32 +: 32] = stat_q[gi];
    end
`else
    assign bus.stat_pkt_cnt = '0;
`endif
endmodule

// File: tb/tb_pkt_wrr_arb_avlstrm.sv
// tb/tb_pkt_wrr_arb_avlstrm.sv - self-checking bench for pkt_wrr_arb_avlstrm
module tb_pkt_wrr_arb_avlstrm;
    localparam int N  = 5;
    localparam int DW = 512;
    localparam int WW = 4;
    localparam int EW = 6;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    pkt_wrr_arb_avlstrm_if #(.N(N), .DW(DW), .WW(WW)) bus ();

    pkt_wrr_arb_avlstrm #(.N(N), .DW(DW), .WW(WW)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    typedef struct {
        logic [N-1:0] mask;
        logic         af;
        logic         rdy;
        logic [N-1:0] exp_gv;
        logic [N-1:0] exp_ir;
    } vec_t;

    beat_t srcq  [N][$];
    beat_t pendb [N][$];
    int    pendn [N][$];
    beat_t expq  [$];
    int    seq_ports [$];
    int    w    [N];
    int    cum  [N];
    int    pseq [N];
    int    mptr;
    int    eop_cnt;
    int    checks;
    int    failures;
    int    gap_pct, rdy_pct, af_pct;
    logic [N-1:0] force_gap;
    logic         force_af;
    logic [N-1:0] s_gv, s_ir;
    logic         hold_prev;
    beat_t        prev_out;
    vec_t         tbl [6];

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic bit same(input beat_t a, input beat_t b);
        return (a.data == b.data) && (a.sop == b.sop) && (a.eop == b.eop) && (a.empty == b.empty);
    endfunction

    function automatic logic [63:0] summ(input beat_t a);
        return {a.sop, a.eop, a.empty, a.data[55:0]};
    endfunction

    task automatic apply_weights();
        for (int i = 0; i < N; i++) bus.cfg_weight[i*WW +: WW] = WW'(w[i]);
    endtask

    task automatic add_pkt(input int port, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            for (int j = 0; j < DW/32; j++) b.data[j*32 +: 32] = $urandom();
            b.data[31:0] = {8'(port), 12'(pseq[port]), 12'(k)};
            b.sop   = (k == 0);
            b.eop   = (k == len - 1);
            b.empty = b.eop ? EW'($urandom_range(63)) : '0;
            srcq[port].push_back(b);
            pendb[port].push_back(b);
        end
        pendn[port].push_back(len);
        pseq[port]++;
    endtask

    // Reference: whole packets in WRR turns, each turn min(max(weight,1), backlog) packets.
    task automatic build_expected();
        int rem [N];
        int total, g, n, len;
        total = 0;
        for (int i = 0; i < N; i++) begin
            rem[i] = pendn[i].size();
            total += rem[i];
        end
        while (total > 0) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && rem[(mptr + k) % N] > 0) g = (mptr + k) % N;
            end
            n = (w[g] < 1) ? 1 : w[g];
            if (n > rem[g]) n = rem[g];
            for (int p = 0; p < n; p++) begin
                len = pendn[g].pop_front();
                for (int k = 0; k < len; k++) expq.push_back(pendb[g].pop_front());
                cum[g]++;
                rem[g]--;
                total--;
            end
            mptr = (g + 1) % N;
        end
    endtask

    function automatic bit srcs_busy();
        for (int i = 0; i < N; i++) if (srcq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic cycle();
        logic [N-1:0] v;
        beat_t b, cur, e;
        @(negedge Clk);
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                b = srcq[i][0];
                bus.in_data[i*DW +: DW]  = b.data;
                bus.in_sop[i]            = b.sop;
                bus.in_eop[i]            = b.eop;
                bus.in_empty[i*EW +: EW] = b.empty;
                v[i] = !(!b.sop && (force_gap[i] || ($urandom_range(99) < gap_pct)));
            end else begin
                bus.in_sop[i] = 1'b0;
                bus.in_eop[i] = 1'b0;
            end
        end
        bus.in_valid       = v;
        bus.out_ready      = ($urandom_range(99) < rdy_pct);
        bus.out_almostfull = force_af || ($urandom_range(99) < af_pct);
        #1;
        s_gv = bus.grant_vec;
        s_ir = bus.in_ready;
        cur.data  = bus.out_data;
        cur.sop   = bus.out_sop;
        cur.eop   = bus.out_eop;
        cur.empty = bus.out_empty;
        if (hold_prev) chk(bus.out_valid && same(cur, prev_out), "out_hold_stable", summ(cur), summ(prev_out));
        if (bus.out_almostfull) chk(s_ir == '0, "in_ready_under_af", 64'(s_ir), 64'(0));
        chk($countones(s_ir) <= 1, "in_ready_onehot", 64'(s_ir), 64'(s_gv));
        if (bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
                chk(1'b0, "unexpected_out_beat", summ(cur), 64'(0));
            end else begin
                e = expq.pop_front();
                chk(same(cur, e), "out_beat", summ(cur), summ(e));
                if (cur.eop) eop_cnt++;
                if (cur.sop) seq_ports.push_back(int'(cur.data[31:24]));
            end
        end
        hold_prev = bus.out_valid && !bus.out_ready;
        prev_out  = cur;
        for (int i = 0; i < N; i++) if (v[i] && s_ir[i]) void'(srcq[i].pop_front());
    endtask

    task automatic check_stats(input string nm);
        logic [31:0] req;
        for (int i = 0; i < N; i++) begin
`ifdef PKT_ARB_STATS_EN
            req = 32'(cum[i]);
`else
            req = 32'd0;
`endif
            chk(bus.stat_pkt_cnt[i*32 +: 32] == req, {nm, "_stat"}, 64'(bus.stat_pkt_cnt[i*32 +: 32]), 64'(req));
        end
    endtask

    task automatic drain(input int max_cyc, input string nm);
        int n;
        n = 0;
        while ((expq.size() > 0 || srcs_busy() || bus.out_valid) && n < max_cyc) begin
            cycle();
            n++;
        end
        chk(n < max_cyc, {nm, "_drain_timeout"}, 64'(n), 64'(max_cyc));
        check_stats(nm);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst_n = 1'b0;
        bus.in_valid = '0;
        bus.out_ready = 1'b1;
        bus.out_almostfull = 1'b0;
        force_gap = '0;
        force_af = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            pendb[i].delete();
            pendn[i].delete();
            cum[i] = 0;
        end
        expq.delete();
        seq_ports.delete();
        mptr = 0;
        eop_cnt = 0;
        hold_prev = 1'b0;
    endtask

    initial begin
        int n;
        checks = 0;
        failures = 0;
        gap_pct = 0; rdy_pct = 100; af_pct = 0;
        force_gap = '0; force_af = 1'b0; hold_prev = 1'b0;
        for (int i = 0; i < N; i++) begin w[i] = 1; cum[i] = 0; pseq[i] = 0; end
        bus.cfg_weight = '0; bus.in_valid = '0; bus.in_data = '0; bus.in_sop = '0;
        bus.in_eop = '0; bus.in_empty = '0; bus.out_ready = 1'b1; bus.out_almostfull = 1'b0;
        apply_weights();

        tbl[0] = '{5'b00001, 1'b0, 1'b1, 5'b00001, 5'b00001};
        tbl[1] = '{5'b10100, 1'b0, 1'b1, 5'b00100, 5'b00100};
        tbl[2] = '{5'b10000, 1'b0, 1'b0, 5'b10000, 5'b10000};
        tbl[3] = '{5'b01010, 1'b1, 1'b1, 5'b00010, 5'b00000};
        tbl[4] = '{5'b11111, 1'b1, 1'b0, 5'b00001, 5'b00000};
        tbl[5] = '{5'b00000, 1'b0, 1'b1, 5'b00000, 5'b00000};

        // Reset held with every port requesting.
        @(negedge Clk);
        Rst_n = 1'b0;
        bus.in_valid = '1; bus.in_sop = '1; bus.in_eop = '1;
        repeat (3) @(posedge Clk);
        #1;
        chk(bus.out_valid == 1'b0, "reset_out_valid", 64'(bus.out_valid), 64'(0));
        chk(bus.in_ready == '0, "reset_in_ready", 64'(bus.in_ready), 64'(0));
        chk(bus.grant_vec == '0, "reset_grant_vec", 64'(bus.grant_vec), 64'(0));
        check_stats("reset");

        // First grant after reset: scan from port 0, bubble cycle, then in_ready gated by af.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            @(negedge Clk);
            bus.in_valid = tbl[t].mask; bus.in_sop = '1; bus.in_eop = '1;
            bus.out_almostfull = tbl[t].af; bus.out_ready = tbl[t].rdy;
            #1;
            chk(bus.grant_vec == '0, "tbl_idle_grant", 64'(bus.grant_vec), 64'(0));
            chk(bus.in_ready == '0, "tbl_idle_ready", 64'(bus.in_ready), 64'(0));
            @(negedge Clk);
            #1;
            chk(bus.grant_vec == tbl[t].exp_gv, "tbl_grant", 64'(bus.grant_vec), 64'(tbl[t].exp_gv));
            chk(bus.in_ready == tbl[t].exp_ir, "tbl_ready", 64'(bus.in_ready), 64'(tbl[t].exp_ir));
        end

        // Equal weights, five ports x 10 three-beat packets.
        do_reset();
        for (int i = 0; i < N; i++) w[i] = 1;
        apply_weights();
        for (int p = 0; p < 10; p++) for (int i = 0; i < N; i++) add_pkt(i, 3);
        build_expected();
        drain(2000, "equal_w");
        chk(eop_cnt == 50, "equal_w_eops", 64'(eop_cnt), 64'(50));
        for (int k = 0; k < seq_ports.size(); k++) begin
            chk(seq_ports[k] == k % N, "equal_w_order", 64'(seq_ports[k]), 64'(k % N));
        end

        // Port 4 weight 3: alone, then sharing with port 0 at 3:1.
        do_reset();
        w[4] = 3;
        apply_weights();
        for (int p = 0; p < 3; p++) add_pkt(4, 2);
        build_expected();
        drain(500, "w3_alone");
        seq_ports.delete();
        for (int p = 0; p < 4; p++) add_pkt(0, 2);
        for (int p = 0; p < 12; p++) add_pkt(4, 1 + p % 3);
        build_expected();
        drain(1000, "w3_share");
        chk(seq_ports.size() == 16, "w3_pkt_count", 64'(seq_ports.size()), 64'(16));
        for (int k = 0; k < seq_ports.size(); k++) begin
            chk(seq_ports[k] == ((k % 4 == 0) ? 0 : 4), "w3_order", 64'(seq_ports[k]), 64'((k % 4 == 0) ? 0 : 4));
        end
        w[4] = 1;
        apply_weights();

        // Port 2 gaps mid-packet while port 3 waits.
        do_reset();
        add_pkt(2, 6);
        add_pkt(3, 2);
        build_expected();
        n = 0;
        while (srcq[2].size() > 4 && n < 20) begin cycle(); n++; end
        chk(n < 20, "gap_setup_timeout", 64'(n), 64'(20));
        force_gap[2] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk(s_gv == 5'b00100, "gap_grant_held", 64'(s_gv), 64'(5'b00100));
            chk(s_ir[3] == 1'b0, "gap_port3_ready", 64'(s_ir[3]), 64'(0));
        end
        force_gap[2] = 1'b0;
        drain(200, "gap");

        // Almost-full for 5 cycles mid-packet, random egress backpressure.
        do_reset();
        rdy_pct = 50;
        add_pkt(1, 8);
        add_pkt(3, 3);
        build_expected();
        n = 0;
        while (srcq[1].size() > 5 && n < 100) begin cycle(); n++; end
        chk(n < 100, "af_setup_timeout", 64'(n), 64'(100));
        force_af = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk(s_ir == '0, "af_in_ready", 64'(s_ir), 64'(0));
        end
        force_af = 1'b0;
        drain(500, "af");

        // Randomized traffic against the packet-level WRR model.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            gap_pct = 30; rdy_pct = 70; af_pct = 15;
            for (int i = 0; i < N; i++) w[i] = $urandom_range(4);
            apply_weights();
            for (int p = 0; p < 5; p++) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(99) < 60) add_pkt(i, $urandom_range(1, 4));
                end
            end
            build_expected();
            drain(5000, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
